imem_loader: RTL and testbench

- Boot-time writer for the instruction memory; the write-side counterpart of the PC-driven, negedge-read instruction store.
- Accepts a byte stream with a valid/ready handshake: a 16-bit little-endian word count, then instruction bytes in little-endian order.
- Packs each group of 4 bytes into a 32-bit instruction and drives a single-cycle write strobe on the memory write port.
- Holds the core in hold while a load is in progress.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: shifts stream bytes into a word, first byte ends up in bits [7:0].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          load,
    input  logic [7:0]                    byte_in,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_full
);

    logic [1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word    <= '0;
            count_q <= '0;
        end else if (clear) begin
            word    <= '0;
            count_q <= '0;
        end else if (load) begin
            word    <= {byte_in, word[8*BYTES_PER_WORD-1:8]};
            count_q <= count_q + 2'd1;
        end
    end

    // Asserted on the load that completes the word, so the FSM can leave DATA without an idle cycle.
    assign word_full = load && (count_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length-prefixed byte stream -> 32-bit word writes.
// Optional trailing XOR check byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   we,
    output logic [INS_ADDRESS-1:0] wa,
    output logic [INS_W-1:0]       wd,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int IDX_W = INS_ADDRESS - 2;
    localparam int DEPTH = 2 ** IDX_W;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic [LEN_W-1:0] len_full;
    logic             accept;
    logic             last_word;
    logic             packer_clear;
    logic             packer_load;
    logic             word_full;
    logic [INS_W-1:0] packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    assign accept    = in_valid && in_ready;
    assign len_full  = {in_data, len_q[7:0]};
    assign last_word = ({{(LEN_W-IDX_W){1'b0}}, idx_q} == (len_q - LEN_W'(1)));

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (packer_clear),
        .load      (packer_load),
        .byte_in   (in_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                LEN0:    if (accept) len_q[7:0] <= in_data;
                LEN1: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        idx_q       <= '0;
                    end
                end
                // The final write leaves the index in place so it never wraps at full depth.
                WRITE:   if (!last_word) idx_q <= idx_q + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (packer_clear && state != LEN1) begin
            chk_q <= '0;
        end else if (packer_load) begin
            chk_q <= chk_q ^ in_data;
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        packer_clear = 1'b0;
        packer_load  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt    = LEN0;
                    packer_clear = 1'b1;
                end
            end
            LEN0: if (accept) state_nxt = LEN1;
            LEN1: begin
                if (accept) begin
                    if (len_full == '0) begin
                        state_nxt = DONE;
                    end else if (len_full > LEN_W'(DEPTH)) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt    = DATA;
                        packer_clear = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    packer_load = 1'b1;
                    if (word_full) state_nxt = WRITE;
                end
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_nxt = last_word ? CHK : DATA;
`else
                state_nxt = last_word ? DONE : DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_nxt = (in_data == chk_q) ? DONE : ERR;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
    assign busy     = in_ready || (state == WRITE);
    assign we       = (state == WRITE);
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign wa       = {idx_q, 2'b00};
    assign wd       = packed_word;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random word loads checked against an address/data model.
module tb_imem_loader;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader #(.INS_ADDRESS(9), .INS_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct packed {
        logic [8:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] load_words[$];
    logic [31:0] mem [DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: every write strobe is matched against the oldest expected write and mirrored into memory.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            wr_t e;
            checkOutput("we_excl_ready", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", {23'd0, wa}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wa", {23'd0, wa}, {23'd0, e.wa});
                checkOutput("wd", wd, e.wd);
            end
            mem[wa[8:2]] = wd;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        int waited = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("handshake_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fillRandom(input int n);
        load_words.delete();
        for (int i = 0; i < n; i++) load_words.push_back($urandom());
    endtask

    task automatic runLoad(input int len_field, input bit gaps, input bit bad_chk,
                           input int abort_after, input bit start_mid);
        logic [7:0]  b;
        logic [7:0]  xsum = 8'h00;
        logic [15:0] len16;
        int          sent = 0;
        bit          exp_ok;
        len16 = len_field[15:0];

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_done_clr", {31'd0, done}, 32'd0);
        checkOutput("start_err_clr", {31'd0, err}, 32'd0);

        applyStimulus(len16[7:0], 1'b0);
        applyStimulus(len16[15:8], gaps);
        if (len_field == 0) checkOutput("zero_len_done", {31'd0, done}, 32'd1);

        if (len_field > 0 && len_field <= DEPTH) begin
            for (int w = 0; w < len_field; w++) begin
                for (int k = 0; k < 4; k++) begin
                    b = load_words[w][8*k +: 8];
                    if (k == 3) exp_q.push_back('{wa: 9'(4 * w), wd: load_words[w]});
                    if (start_mid && sent == 2) start = 1'b1;
                    applyStimulus(b, gaps);
                    start = 1'b0;
                    xsum ^= b;
                    sent++;
                    if (sent == abort_after) begin
                        in_valid = 1'b0;
                        rst_n    = 1'b0;
                        #1;
                        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
                        checkOutput("abort_we", {31'd0, we}, 32'd0);
                        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
                        checkOutput("abort_done", {31'd0, done}, 32'd0);
                        checkOutput("abort_err", {31'd0, err}, 32'd0);
                        checkOutput("abort_wa", {23'd0, wa}, 32'd0);
                        checkOutput("abort_wd", wd, 32'd0);
                        checkOutput("abort_mem0", mem[0], load_words[0]);
                        checkOutput("abort_pending", exp_q.size(), 32'd0);
                        exp_q.delete();
                        @(negedge clk);
                        rst_n = 1'b1;
                        return;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            applyStimulus(bad_chk ? (xsum ^ 8'h01) : xsum, gaps);
`endif
        end

        if (len_field == 0) exp_ok = 1'b1;
        else if (len_field > DEPTH) exp_ok = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else exp_ok = !bad_chk;
`else
        else exp_ok = 1'b1;
`endif

        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        checkOutput("end_busy", {31'd0, busy}, 32'd0);
        checkOutput("end_done", {31'd0, done}, {31'd0, exp_ok});
        checkOutput("end_err", {31'd0, err}, {31'd0, !exp_ok});
        checkOutput("end_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("end_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_we", {31'd0, we}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_wa", {23'd0, wa}, 32'd0);
        checkOutput("rst_wd", wd, 32'd0);
        rst_n = 1'b1;

        load_words = '{32'h00000013, 32'h00100093};
        runLoad(2, 1'b0, 1'b0, -1, 1'b0);

        load_words.delete();
        runLoad(0, 1'b0, 1'b0, -1, 1'b0);
        runLoad(129, 1'b0, 1'b0, -1, 1'b0);
        runLoad($urandom_range(65535, DEPTH + 2), 1'b0, 1'b0, -1, 1'b0);

        fillRandom(3);
        runLoad(3, 1'b1, 1'b0, -1, 1'b1);

        fillRandom(4);
        runLoad(4, 1'b0, 1'b0, 6, 1'b0);
        fillRandom(4);
        runLoad(4, 1'b0, 1'b0, -1, 1'b0);

        fillRandom(DEPTH);
        runLoad(DEPTH, 1'b0, 1'b0, -1, 1'b0);
        checkOutput("full_depth_last", mem[DEPTH-1], load_words[DEPTH-1]);

        repeat (6) begin
            n = $urandom_range(8, 1);
            fillRandom(n);
            runLoad(n, 1'($urandom_range(1, 0)), 1'b0, -1, 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        load_words = '{32'hDEADBEEF};
        runLoad(1, 1'b0, 1'b0, -1, 1'b0);
        runLoad(1, 1'b0, 1'b1, -1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
